// File: rtl/mode_step_controller.sv
// Front-panel mode sequencer: synchronises and debounces two pushbuttons, then steps a wrapping mode register.
// Define MODE_AUTO_REPEAT_EN to add per-key hold-to-repeat stepping.
module mode_step_controller #(
    parameter int unsigned NUM_MODES       = 4,
    parameter int unsigned SEL_W           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [1:0]       KEY,
    output logic [SEL_W-1:0] module_select,
    output logic             mode_changed,
    output logic [1:0]       key_held
);

    localparam int unsigned DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_MODES - 1);

    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       w_d;
    logic [1:0]       w_press;
    logic             w_fwd;
    logic             w_bwd;
    logic             w_step;
    logic [SEL_W-1:0] w_sel_nxt;
    logic [SEL_W-1:0] r_sel;
    logic             r_changed;

    // Two-flop synchroniser; idle (released) level is 1
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
        end else begin
            r_sync1 <= KEY;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_deb
        logic           r_d;
        logic           r_d_dly;
        logic [DBW-1:0] r_db_cnt;

        // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                r_d      <= 1'b1;
                r_d_dly  <= 1'b1;
                r_db_cnt <= '0;
            end else begin
                r_d_dly <= r_d;
                if (r_sync2[g] == r_d) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    r_d      <= r_sync2[g];
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + DBW'(1);
                end
            end
        end

        assign w_d[g]     = r_d;
        assign w_press[g] = r_d_dly & ~r_d;
    end

`ifdef MODE_AUTO_REPEAT_EN
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DELAY   = 2'd1;
    localparam logic [1:0] ST_REPEAT  = 2'd2;
    localparam logic [1:0] ST_BLOCKED = 2'd3;
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW      = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    logic [1:0] w_rpt_step;

    for (genvar g = 0; g < 2; g++) begin : g_rpt
        logic [1:0]    r_state;
        logic [1:0]    w_state_nxt;
        logic [RW-1:0] r_rpt_cnt;
        logic [RW-1:0] w_rpt_cnt_nxt;
        logic          w_step_c;

        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                r_state   <= ST_IDLE;
                r_rpt_cnt <= '0;
            end else begin
                r_state   <= w_state_nxt;
                r_rpt_cnt <= w_rpt_cnt_nxt;
            end
        end

        // Release wins, then a press of the other key blocks repeating until both are released
        always_comb begin
            w_state_nxt   = r_state;
            w_rpt_cnt_nxt = r_rpt_cnt;
            w_step_c      = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_press[g]) begin
                        w_rpt_cnt_nxt = '0;
                        w_state_nxt   = (w_press[1-g] || !w_d[1-g]) ? ST_BLOCKED : ST_DELAY;
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    if (w_d[g]) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_press[1-g]) begin
                        w_state_nxt = ST_BLOCKED;
                    end else if (r_rpt_cnt == ((r_state == ST_DELAY) ? RW'(REPEAT_DELAY - 1)
                                                                     : RW'(REPEAT_PERIOD - 1))) begin
                        w_state_nxt   = ST_REPEAT;
                        w_rpt_cnt_nxt = '0;
                        w_step_c      = 1'b1;
                    end else begin
                        w_rpt_cnt_nxt = r_rpt_cnt + RW'(1);
                    end
                end
                default: begin
                    if (&w_d) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            endcase
        end

        assign w_rpt_step[g] = w_step_c;
    end

    assign w_fwd = w_press[0] | w_rpt_step[0];
    assign w_bwd = w_press[1] | w_rpt_step[1];
`else
    localparam int unsigned unused_repeat_cfg = REPEAT_DELAY ^ REPEAT_PERIOD;

    assign w_fwd = w_press[0];
    assign w_bwd = w_press[1];
`endif

    // Step resolution: opposing steps cancel; an out-of-range value recovers to 0
    always_comb begin
        w_sel_nxt = r_sel;
        w_step    = w_fwd ^ w_bwd;
        if (w_step) begin
            if (32'(r_sel) >= NUM_MODES) begin
                w_sel_nxt = '0;
            end else if (w_fwd) begin
                w_sel_nxt = (r_sel == SEL_MAX) ? '0 : r_sel + SEL_W'(1);
            end else begin
                w_sel_nxt = (r_sel == '0) ? SEL_MAX : r_sel - SEL_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_sel     <= '0;
            r_changed <= 1'b0;
        end else begin
            r_sel     <= w_sel_nxt;
            r_changed <= w_step;
        end
    end

    assign module_select = r_sel;
    assign mode_changed  = r_changed;
    assign key_held      = ~w_d;

endmodule

// File: tb/tb_mode_step_controller.sv
// Bench for mode_step_controller: directed test-plan cases plus random key activity against a window/arithmetic model.
// Expectations follow MODE_AUTO_REPEAT_EN when it is defined for the build.
module tb_mode_step_controller;

    localparam int unsigned NUM_MODES = 4;
    localparam int unsigned SEL_W     = 2;
    localparam int unsigned DB        = 4;
    localparam int unsigned RD        = 10;
    localparam int unsigned RP        = 3;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic [1:0]       KEY;
    logic [SEL_W-1:0] module_select;
    logic             mode_changed;
    logic [1:0]       key_held;

    always #5 CLK = ~CLK;

    mode_step_controller #(
        .NUM_MODES      (NUM_MODES),
        .SEL_W          (SEL_W),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .KEY          (KEY),
        .module_select(module_select),
        .mode_changed (mode_changed),
        .key_held     (key_held)
    );

    int n_checks = 0;
    int n_errors = 0;
    int pulse_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: state after each rising edge, derived from sample windows and hold times
    int       m_t;
    int       m_sel;
    bit       m_chg;
    bit [1:0] m_d;
    bit [1:0] m_fell;
    bit [1:0] m_klast;
    bit [1:0] m_s_hist[$];
    int       m_press_t[2];
    bit       m_blocked;

    task automatic model_reset();
        m_t       = 0;
        m_sel     = 0;
        m_chg     = 1'b0;
        m_d       = 2'b11;
        m_fell    = 2'b00;
        m_klast   = 2'b11;
        m_s_hist  = {};
        m_press_t = '{-1000, -1000};
        m_blocked = 1'b0;
    endtask

    task automatic model_edge(input bit [1:0] k);
        bit [1:0] d_prev;
        bit [1:0] press;
        bit [1:0] rep;
        bit       fwd;
        bit       bwd;
        d_prev = m_d;
        press  = m_fell;
        rep    = 2'b00;
        m_t++;
`ifdef MODE_AUTO_REPEAT_EN
        if (&d_prev) m_blocked = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (press[i]) begin
                if (!d_prev[1-i]) m_blocked = 1'b1;
                m_press_t[i] = m_t;
            end
        end
        for (int i = 0; i < 2; i++) begin
            int dt;
            dt = m_t - m_press_t[i] - int'(RD);
            if (!m_blocked && !d_prev[i] && dt >= 0 && (dt % int'(RP)) == 0) rep[i] = 1'b1;
        end
`endif
        fwd   = press[0] | rep[0];
        bwd   = press[1] | rep[1];
        m_chg = fwd ^ bwd;
        if (fwd && !bwd) m_sel = (m_sel + 1) % NUM_MODES;
        else if (bwd && !fwd) m_sel = (m_sel + NUM_MODES - 1) % NUM_MODES;
        for (int i = 0; i < 2; i++) begin
            bit flip;
            flip = (m_s_hist.size() >= DB);
            for (int j = 0; j < int'(DB) && flip; j++)
                if (m_s_hist[m_s_hist.size() - 1 - j][i] == d_prev[i]) flip = 1'b0;
            if (flip) m_d[i] = ~d_prev[i];
        end
        m_fell = d_prev & ~m_d;
        m_s_hist.push_back(m_klast);
        if (m_s_hist.size() > DB) void'(m_s_hist.pop_front());
        m_klast = k;
    endtask

    task automatic cycle(input logic [1:0] k);
        bit [1:0] exp_held;
        KEY = k;
        @(posedge CLK);
        if (RST_N) model_edge(k);
        else model_reset();
        @(negedge CLK);
        exp_held = ~m_d;
        check("module_select", module_select, m_sel);
        check("mode_changed", mode_changed, m_chg);
        check("key_held", key_held, exp_held);
        if (mode_changed === 1'b1) pulse_cnt++;
    endtask

    task automatic run(input logic [1:0] k, input int n);
        for (int j = 0; j < n; j++) cycle(k);
    endtask

    initial begin
        RST_N = 1'b0;
        KEY   = 2'b11;
        model_reset();
        run(2'b11, 2);
        check("rst_sel", module_select, 0);
        check("rst_chg", mode_changed, 0);
        check("rst_held", key_held, 0);
        RST_N = 1'b1;
        run(2'b11, 4);

        // Forward presses: step lands at edge N+6, wraps after four
        for (int p = 1; p <= 4; p++) begin
            pulse_cnt = 0;
            run(2'b10, 6);
            check("fwd_before_n6", module_select, (p - 1) % 4);
            run(2'b10, 1);
            check("fwd_at_n6", module_select, p % 4);
            check("fwd_pulse_n6", mode_changed, 1);
            run(2'b10, 1);
            run(2'b11, 8);
            check("fwd_pulses", pulse_cnt, 1);
        end

        // Backward key bouncing then settling low: one step 0 -> 3
        pulse_cnt = 0;
        for (int j = 0; j < 5; j++) begin
            run(2'b01, 2);
            run(2'b11, 2);
        end
        run(2'b01, 9);
        run(2'b11, 8);
        check("bwd_sel", module_select, 3);
        check("bwd_pulses", pulse_cnt, 1);

        pulse_cnt = 0;
        run(2'b01, 3);
        run(2'b11, 8);
        check("glitch_sel", module_select, 3);
        check("glitch_pulses", pulse_cnt, 0);

        // Simultaneous press cancels
        pulse_cnt = 0;
        run(2'b00, 8);
        check("both_held", key_held, 3);
        check("both_sel", module_select, 3);
        check("both_pulses", pulse_cnt, 0);
        run(2'b11, 8);

        run(2'b10, 9);
        run(2'b11, 8);
        check("pre_hold_sel", module_select, 0);

        // Long hold of the forward key
        pulse_cnt = 0;
        run(2'b10, 30);
        run(2'b11, 10);
`ifdef MODE_AUTO_REPEAT_EN
        check("hold30_pulses", pulse_cnt, 8);
        check("hold30_sel", module_select, 0);
`else
        check("hold30_pulses", pulse_cnt, 1);
        check("hold30_sel", module_select, 1);
`endif

        // Other key pressed while holding: only the two press steps
        pulse_cnt = 0;
        run(2'b10, 8);
        run(2'b00, 20);
        run(2'b11, 12);
        check("block_pulses", pulse_cnt, 2);

        pulse_cnt = 0;
        run(2'b10, 100);
        run(2'b11, 10);
`ifdef MODE_AUTO_REPEAT_EN
        check("hold100_pulses", pulse_cnt, 31);
`else
        check("hold100_pulses", pulse_cnt, 1);
`endif

        // Reset in mid-debounce with the key held through release
        run(2'b10, 3);
        RST_N = 1'b0;
        run(2'b10, 2);
        check("rst_mid_sel", module_select, 0);
        check("rst_mid_held", key_held, 0);
        RST_N = 1'b1;
        pulse_cnt = 0;
        run(2'b10, 6);
        check("rst_restart_n5", module_select, 0);
        run(2'b10, 1);
        check("rst_restart_n6", module_select, 1);
        run(2'b10, 2);
        run(2'b11, 8);
        check("rst_restart_pulses", pulse_cnt, 1);

        // Random key activity, bounces and occasional resets
        for (int seg = 0; seg < 250; seg++) begin
            int unsigned kind;
            logic [1:0]  k;
            kind = $urandom_range(0, 19);
            k    = ($urandom_range(0, 2) == 0) ? 2'b11 : 2'($urandom_range(0, 3));
            if (kind == 0) begin
                RST_N = 1'b0;
                run(k, int'($urandom_range(1, 2)));
                RST_N = 1'b1;
            end else if (kind < 5) begin
                int n;
                n = int'($urandom_range(2, 10));
                for (int j = 0; j < n; j++) cycle(2'($urandom_range(0, 3)));
            end else begin
                run(k, int'($urandom_range(1, 30)));
            end
        end
        run(2'b11, 12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
